// File: rtl/io_timer_pkg.sv
// Shared register map, CTRL/STATUS bit positions and reset constants for io_timer.
package io_timer_pkg;

  localparam logic [2:0] REG_TIME_LO = 3'd0;
  localparam logic [2:0] REG_TIME_HI = 3'd1;
  localparam logic [2:0] REG_CMP_LO  = 3'd2;
  localparam logic [2:0] REG_CMP_HI  = 3'd3;
  localparam logic [2:0] REG_CTRL    = 3'd4;
  localparam logic [2:0] REG_STATUS  = 3'd5;

  localparam int CTRL_EN     = 0;
  localparam int CTRL_IE     = 1;
  localparam int PRESC_LSB   = 8;
  localparam int PRESC_MSB   = 15;
  localparam int STATUS_PEND = 0;

  localparam logic [63:0] TIME_RST = 64'h0;
  localparam logic [63:0] CMP_RST  = 64'hFFFF_FFFF_FFFF_FFFF;

  // The window is 8 words, so only address bits [15:5] (word bits [13:3]) are compared.
  function automatic logic in_window(input logic [10:0] adr_hi, input logic [10:0] base_hi);
    return adr_hi == base_hi;
  endfunction

endpackage

// File: rtl/io_timer_prescaler.sv
// 8-bit prescaler: one-cycle tick every presc+1 enabled cycles, cleared on CTRL writes.
module io_timer_prescaler (
  input  logic       clk,
  input  logic       rst,
  input  logic       en,
  input  logic [7:0] presc,
  input  logic       clr,
  output logic       tick
);

  logic [7:0] cnt_q;

  assign tick = en && (cnt_q == presc);

  // NOTE: sequential state is written with non-blocking assignments only, so every
  // flop samples pre-edge values regardless of block ordering.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= 8'd0;
    end else if (clr) begin
      cnt_q <= 8'd0;
    end else if (en) begin
      cnt_q <= tick ? 8'd0 : cnt_q + 8'd1;
    end
  end

endmodule

// File: rtl/io_timer.sv
// 64-bit timer/compare slave on the daisy-chained dma_io bus with a level interrupt.
module io_timer
  import io_timer_pkg::*;
#(
  parameter logic [13:0] BASE_WADR = 14'h3000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        dma_io_we,
  input  logic [13:0] dma_io_wadr,
  input  logic [31:0] dma_io_wdata,
  input  logic [13:0] dma_io_radr,
  input  logic        dma_io_radr_en,
  input  logic [31:0] dma_io_rdata_in,
  output logic [31:0] dma_io_rdata,
  output logic        timer_irq
);

  logic [63:0] time_q;
  logic [63:0] cmp_q;
  logic [31:0] shadow_q;
  logic [31:0] rd_data_q;
  logic        rd_valid_q;
  logic        pend_q;
  logic        en_q;
  logic        ie_q;
  logic [7:0]  presc_q;

  logic        wr_hit;
  logic        rd_hit;
  logic [2:0]  woff;
  logic [2:0]  roff;
  logic        wr_ctrl;
  logic        tick;
  logic        match;
  logic [31:0] rd_mux;

  assign woff    = dma_io_wadr[2:0];
  assign roff    = dma_io_radr[2:0];
  assign wr_hit  = dma_io_we && in_window(dma_io_wadr[13:3], BASE_WADR[13:3]);
  assign rd_hit  = dma_io_radr_en && in_window(dma_io_radr[13:3], BASE_WADR[13:3]);
  assign wr_ctrl = wr_hit && (woff == REG_CTRL);
  assign match   = en_q && (time_q >= cmp_q);

  io_timer_prescaler u_prescaler (
    .clk   (clk),
    .rst   (rst),
    .en    (en_q),
    .presc (presc_q),
    .clr   (wr_ctrl),
    .tick  (tick)
  );

  // NOTE: every output of a combinational block gets a default first, so no
  // path through the case can leave it unassigned and infer a latch.
  always_comb begin
    rd_mux = 32'd0;
    case (roff)
      REG_TIME_LO: rd_mux = time_q[31:0];
      REG_TIME_HI: rd_mux = shadow_q;
      REG_CMP_LO:  rd_mux = cmp_q[31:0];
      REG_CMP_HI:  rd_mux = cmp_q[63:32];
      REG_CTRL:    rd_mux = {16'd0, presc_q, 6'd0, ie_q, en_q};
      REG_STATUS:  rd_mux = {31'd0, pend_q};
      default:     rd_mux = 32'd0;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      time_q     <= TIME_RST;
      cmp_q      <= CMP_RST;
      shadow_q   <= 32'd0;
      rd_data_q  <= 32'd0;
      rd_valid_q <= 1'b0;
      pend_q     <= 1'b0;
      en_q       <= 1'b0;
      ie_q       <= 1'b0;
      presc_q    <= 8'd0;
    end else begin
      // A bus write to either half takes priority over the tick increment.
      if (wr_hit && woff == REG_TIME_LO) begin
        time_q[31:0] <= dma_io_wdata;
      end else if (wr_hit && woff == REG_TIME_HI) begin
        time_q[63:32] <= dma_io_wdata;
      end else if (tick) begin
        time_q <= time_q + 64'd1;
      end

      if (wr_hit && woff == REG_CMP_LO) cmp_q[31:0]  <= dma_io_wdata;
      if (wr_hit && woff == REG_CMP_HI) cmp_q[63:32] <= dma_io_wdata;

      if (wr_ctrl) begin
        en_q    <= dma_io_wdata[CTRL_EN];
        ie_q    <= dma_io_wdata[CTRL_IE];
        presc_q <= dma_io_wdata[PRESC_MSB:PRESC_LSB];
      end

      if (match) begin
        pend_q <= 1'b1;
      end else if (wr_hit && woff == REG_STATUS && dma_io_wdata[STATUS_PEND]) begin
        pend_q <= 1'b0;
      end

      rd_valid_q <= rd_hit;
      if (rd_hit) rd_data_q <= rd_mux;
      if (rd_hit && roff == REG_TIME_LO) shadow_q <= time_q[63:32];
    end
  end

  assign dma_io_rdata = rd_valid_q ? rd_data_q : dma_io_rdata_in;
  assign timer_irq    = pend_q & ie_q;

endmodule

// File: tb/tb_io_timer.sv
// Scoreboard bench for io_timer: a per-cycle reference model queues expectations, a monitor checks them.
module tb_io_timer;

  localparam logic [13:0] BASE = 14'h3000;

  logic        clk = 1'b0;
  logic        rst;
  logic        dma_io_we;
  logic [13:0] dma_io_wadr;
  logic [31:0] dma_io_wdata;
  logic [13:0] dma_io_radr;
  logic        dma_io_radr_en;
  logic [31:0] dma_io_rdata_in;
  logic [31:0] dma_io_rdata;
  logic        timer_irq;

  io_timer #(.BASE_WADR(BASE)) dut (
    .clk             (clk),
    .rst             (rst),
    .dma_io_we       (dma_io_we),
    .dma_io_wadr     (dma_io_wadr),
    .dma_io_wdata    (dma_io_wdata),
    .dma_io_radr     (dma_io_radr),
    .dma_io_radr_en  (dma_io_radr_en),
    .dma_io_rdata_in (dma_io_rdata_in),
    .dma_io_rdata    (dma_io_rdata),
    .timer_irq       (timer_irq)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        rd;
    logic [31:0] data;
    logic        irq;
  } exp_t;

  exp_t sb[$];
  int   errors = 0;
  int   checks = 0;

  // Reference model state: architectural registers plus enabled-cycle count since the last CTRL write.
  logic [63:0] m_time   = 64'h0;
  logic [63:0] m_cmp    = 64'hFFFF_FFFF_FFFF_FFFF;
  logic [31:0] m_shadow = 32'h0;
  logic        m_en     = 1'b0;
  logic        m_ie     = 1'b0;
  logic        m_pend   = 1'b0;
  int          m_presc  = 0;
  int          m_since  = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] model_read(input logic [2:0] off);
    case (off)
      3'd0: return m_time[31:0];
      3'd1: return m_shadow;
      3'd2: return m_cmp[31:0];
      3'd3: return m_cmp[63:32];
      3'd4: return {16'd0, 8'(m_presc), 6'd0, m_ie, m_en};
      3'd5: return {31'd0, m_pend};
      default: return 32'd0;
    endcase
  endfunction

  // One bus cycle: drive inputs, predict the output of the following cycle, advance the model.
  task automatic bus(input logic we, input logic [13:0] wa, input logic [31:0] wd,
                     input logic re, input logic [13:0] ra, input logic [31:0] up);
    exp_t e;
    logic whit, rhit, tick, match;
    logic [2:0] wo, ro;
    @(negedge clk);
    dma_io_we = we; dma_io_wadr = wa; dma_io_wdata = wd;
    dma_io_radr_en = re; dma_io_radr = ra; dma_io_rdata_in = up;
    whit = we && (wa[13:3] == BASE[13:3]);
    rhit = re && (ra[13:3] == BASE[13:3]);
    wo = wa[2:0];
    ro = ra[2:0];
    e.rd   = rhit;
    e.data = rhit ? model_read(ro) : 32'd0;
    tick  = m_en && ((m_since % (m_presc + 1)) == m_presc);
    match = m_en && (m_time >= m_cmp);
    if (rhit && ro == 3'd0) m_shadow = m_time[63:32];
    if (whit && wo == 3'd4) m_since = 0;
    else if (m_en) m_since++;
    if (whit && wo == 3'd0) m_time[31:0] = wd;
    else if (whit && wo == 3'd1) m_time[63:32] = wd;
    else if (tick) m_time = m_time + 64'd1;
    if (whit && wo == 3'd2) m_cmp[31:0] = wd;
    if (whit && wo == 3'd3) m_cmp[63:32] = wd;
    if (whit && wo == 3'd4) begin
      m_en = wd[0];
      m_ie = wd[1];
      m_presc = int'(wd[15:8]);
    end
    if (match) m_pend = 1'b1;
    else if (whit && wo == 3'd5 && wd[0]) m_pend = 1'b0;
    e.irq = m_pend & m_ie;
    sb.push_back(e);
  endtask

  task automatic wr(input logic [2:0] off, input logic [31:0] d);
    bus(1'b1, BASE | 14'(off), d, 1'b0, 14'd0, $urandom);
  endtask

  task automatic rd(input logic [2:0] off);
    bus(1'b0, 14'd0, 32'd0, 1'b1, BASE | 14'(off), $urandom);
  endtask

  task automatic rdwr(input logic [2:0] off, input logic [31:0] d);
    bus(1'b1, BASE | 14'(off), d, 1'b1, BASE | 14'(off), $urandom);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) bus(1'b0, 14'd0, 32'd0, 1'b0, 14'd0, $urandom);
  endtask

  // Monitor: every cycle the DUT presents either a read response or passthrough data, plus the irq level.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #2;
      if (sb.size() > 0) begin
        e = sb.pop_front();
        if (e.rd) check("rdata", dma_io_rdata, e.data);
        else check("passthrough", dma_io_rdata, dma_io_rdata_in);
        check("timer_irq", {31'd0, timer_irq}, {31'd0, e.irq});
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [13:0] a;
    logic [31:0] d;
    rst = 1'b1;
    dma_io_we = 1'b0; dma_io_wadr = '0; dma_io_wdata = '0;
    dma_io_radr_en = 1'b0; dma_io_radr = '0; dma_io_rdata_in = 32'hA5A5_0001;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    #1;
    check("reset_irq", {31'd0, timer_irq}, 32'd0);
    check("reset_passthrough", dma_io_rdata, 32'hA5A5_0001);

    // Reset values of all eight offsets and an out-of-window read.
    for (int i = 0; i < 8; i++) rd(3'(i));
    bus(1'b0, 14'd0, 32'd0, 1'b1, 14'h0100, 32'hA5A5_0001);
    idle(1);

    // Counting at PRESC=0, then PRESC=3.
    wr(3'd4, 32'h0000_0001);
    idle(10);
    rd(3'd0);
    wr(3'd4, 32'h0000_0301);
    for (int i = 0; i < 10; i++) begin
      idle(3);
      rd(3'd0);
    end

    // 32-bit carry into the high word and full 64-bit wrap.
    wr(3'd4, 32'h0);
    wr(3'd0, 32'hFFFF_FFFE);
    wr(3'd1, 32'h0);
    wr(3'd4, 32'h1);
    idle(2);
    wr(3'd4, 32'h0);
    rd(3'd0); rd(3'd1);
    wr(3'd0, 32'hFFFF_FFFF);
    wr(3'd1, 32'hFFFF_FFFF);
    wr(3'd4, 32'h1);
    idle(1);
    wr(3'd4, 32'h0);
    rd(3'd0); rd(3'd1);

    // Compare, sticky pending flag, set-wins clear and irq drop.
    wr(3'd0, 32'h0); wr(3'd1, 32'h0);
    wr(3'd2, 32'd20); wr(3'd3, 32'h0);
    wr(3'd4, 32'h3);
    idle(24);
    rd(3'd5);
    wr(3'd5, 32'h1);
    rd(3'd5);
    wr(3'd2, 32'hFFFF_FFFF); wr(3'd3, 32'hFFFF_FFFF);
    wr(3'd5, 32'h1);
    idle(2);
    rd(3'd5);

    // Atomic read: HI returns the shadow latched with LO.
    wr(3'd4, 32'h0);
    wr(3'd0, 32'hFFFF_FFFF); wr(3'd1, 32'h0);
    wr(3'd4, 32'h1);
    rd(3'd0);
    idle(1);
    rd(3'd1);
    rd(3'd0);

    // Write beats tick; read of a register being written returns the old value.
    wr(3'd0, 32'd5);
    rd(3'd0);
    rdwr(3'd2, 32'h1234_5678);
    rd(3'd2);
    rd(3'd6); rd(3'd7);

    // Randomized traffic.
    for (int i = 0; i < 1500; i++) begin
      a = ($urandom_range(0, 9) == 0) ? 14'($urandom) : (BASE | 14'($urandom_range(0, 7)));
      d = $urandom;
      if (a[2:0] == 3'd4) d[15:8] = 8'($urandom_range(0, 3));
      if (a[2:0] == 3'd3 || a[2:0] == 3'd1) d = 32'($urandom_range(0, 1));
      bus(($urandom_range(0, 3) == 0), a, d, ($urandom_range(0, 1) == 1),
          ($urandom_range(0, 9) == 0) ? 14'($urandom) : (BASE | 14'($urandom_range(0, 7))),
          $urandom);
    end
    idle(2);

    repeat (3) @(posedge clk);
    #3;
    check("scoreboard_drain", 32'(sb.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
